// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a table of (address, data, wait) steps as register
// writes into the tone generator. Each write holds address/data for one cycle
// before and after a STROBE_HOLD-cycle write_strobe so a slower-clocked
// generator can sample it reliably.
// Optional feature: define TONE_SEQ_LOOP_EN to make playback wrap to step 0 at
// the end of the table instead of stopping; only stop or rst then ends it.
module tone_sequencer #(
  parameter int DEPTH       = 16,
  parameter int TICK_DIV    = 50,
  parameter int STROBE_HOLD = 64,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load_we,
  input  logic [AW-1:0] load_idx,
  input  logic [15:0]   load_entry,
  input  logic [AW:0]   play_len,
  input  logic          start,
  input  logic          stop,
  output logic          write_strobe,
  output logic [2:0]    address,
  output logic [4:0]    data,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  localparam int SW = (STROBE_HOLD > 1) ? $clog2(STROBE_HOLD) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        state;
  logic [15:0]   table_mem [DEPTH];
  logic [AW:0]   len;
  logic [SW-1:0] strobe_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    wait_left;
  logic          stop_req;

  logic [AW-1:0] next_idx;
  logic [AW-1:0] load_sel;
  logic [AW:0]   next_cnt;
  logic          last_step;
  logic          wait_done;
  logic [15:0]   load_word;

  // Entry field extraction: {addr[15:13], data[12:8], wait[7:0]}
  function automatic logic [2:0] f_addr(input logic [15:0] e);
    return e[15:13];
  endfunction

  function automatic logic [4:0] f_data(input logic [15:0] e);
    return e[12:8];
  endfunction

  function automatic logic [7:0] f_wait(input logic [15:0] e);
    return e[7:0];
  endfunction

  // Lengths beyond the table size play the whole table once
  function automatic logic [AW:0] clamp_len(input logic [AW:0] n);
    if (n > (AW+1)'(DEPTH)) begin
      return (AW+1)'(DEPTH);
    end
    return n;
  endfunction

  // Table storage; deliberately not cleared by rst so tunes survive a reset
  always_ff @(posedge clk) begin
    if (en && load_we && !busy) begin
      table_mem[load_idx] <= load_entry;
    end
  end

  // Next-step selection and wait-expiry decode
  always_comb begin
    next_idx  = step_idx + AW'(1);
    next_cnt  = {1'b0, step_idx} + (AW+1)'(1);
    last_step = (next_cnt == len);
    // Starting from IDLE or wrapping after the last step both fetch entry 0
    load_sel  = ((state == S_IDLE) || last_step) ? '0 : next_idx;
    load_word = table_mem[load_sel];
    // wait==0 leaves after one cycle; otherwise leave on the final tick
    wait_done = (wait_left == 8'd0) ||
                ((tick_cnt == TW'(TICK_DIV - 1)) && (wait_left == 8'd1));
  end

  // Playback FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
      busy         <= 1'b0;
      step_idx     <= '0;
      done         <= 1'b0;
      len          <= '0;
      strobe_cnt   <= '0;
      tick_cnt     <= '0;
      wait_left    <= '0;
      stop_req     <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // stop beats start; a zero-length request only acknowledges
          if (!stop && start) begin
            if (play_len == '0) begin
              done <= 1'b1;
            end else begin
              len       <= clamp_len(play_len);
              step_idx  <= '0;
              address   <= f_addr(load_word);
              data      <= f_data(load_word);
              wait_left <= f_wait(load_word);
              busy      <= 1'b1;
              stop_req  <= 1'b0;
              state     <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          stop_req     <= stop_req | stop;
          write_strobe <= 1'b1;
          strobe_cnt   <= SW'(STROBE_HOLD - 1);
          state        <= S_STROBE;
        end

        S_STROBE: begin
          // A stop here is remembered so the strobe is never cut short
          stop_req <= stop_req | stop;
          if (strobe_cnt == '0) begin
            write_strobe <= 1'b0;
            state        <= S_HOLD;
          end else begin
            strobe_cnt <= strobe_cnt - SW'(1);
          end
        end

        S_HOLD: begin
          if (stop_req || stop) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            stop_req <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tick_cnt <= '0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (stop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (wait_done) begin
`ifdef TONE_SEQ_LOOP_EN
            step_idx  <= last_step ? '0 : next_idx;
            address   <= f_addr(load_word);
            data      <= f_data(load_word);
            wait_left <= f_wait(load_word);
            state     <= S_SETUP;
`else
            if (last_step) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              step_idx  <= next_idx;
              address   <= f_addr(load_word);
              data      <= f_data(load_word);
              wait_left <= f_wait(load_word);
              state     <= S_SETUP;
            end
`endif
          end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_cnt  <= '0;
            wait_left <= wait_left - 8'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        default: begin
          busy         <= 1'b0;
          write_strobe <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed bench for tone_sequencer. A timeline model
// expands each playback request into the expected per-cycle bus activity from
// the table contents; a compare process checks every cycle against it.
module tb_tone_sequencer;

  localparam int DEPTH = 16;
  localparam int TD    = 4;
  localparam int SH    = 3;
`ifdef TONE_SEQ_LOOP_EN
  localparam int REPS  = 4;
`else
  localparam int REPS  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, en, load_we, start, stop;
  logic [3:0]  load_idx;
  logic [15:0] load_entry;
  logic [4:0]  play_len;
  logic        write_strobe, busy, done;
  logic [2:0]  address;
  logic [4:0]  data;
  logic [3:0]  step_idx;

  tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .STROBE_HOLD(SH)) dut (
    .clk(clk), .rst(rst), .en(en), .load_we(load_we), .load_idx(load_idx),
    .load_entry(load_entry), .play_len(play_len), .start(start), .stop(stop),
    .write_strobe(write_strobe), .address(address), .data(data),
    .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 0 setup, 1 strobe, 2 hold, 3 wait, 4 done, -1 idle
  typedef struct {
    logic       strobe;
    logic [2:0] addr;
    logic [4:0] data;
    logic       busy;
    logic [3:0] idx;
    logic       done;
    int         kind;
  } rec_t;

  rec_t        q[$];
  rec_t        last;
  rec_t        cur;
  logic [15:0] tbl [DEPTH];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_on = 0;
  logic        en_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic s, input logic [15:0] e, input logic b,
                              input logic [3:0] i, input logic dn, input int k);
    rec_t r;
    r.strobe = s; r.addr = e[15:13]; r.data = e[12:8];
    r.busy = b; r.idx = i; r.done = dn; r.kind = k;
    return r;
  endfunction

  function automatic rec_t idle_of(input rec_t r);
    rec_t o;
    o = r; o.strobe = 1'b0; o.busy = 1'b0; o.done = 1'b0; o.kind = -1;
    return o;
  endfunction

  function automatic rec_t zero_rec();
    rec_t r;
    r.strobe = 0; r.addr = 0; r.data = 0; r.busy = 0; r.idx = 0; r.done = 0; r.kind = -1;
    return r;
  endfunction

  // Expand a playback of n steps into per-cycle expectations
  task automatic push_play(input int n);
    int l, w;
    logic [15:0] e;
    rec_t r;
    l = (n > DEPTH) ? DEPTH : n;
    for (int p = 0; p < REPS; p++) begin
      for (int i = 0; i < l; i++) begin
        e = tbl[i];
        w = int'(e[7:0]) * TD;
        if (w < 1) w = 1;
        q.push_back(mk(1'b0, e, 1'b1, 4'(i), 1'b0, 0));
        for (int s = 0; s < SH; s++) q.push_back(mk(1'b1, e, 1'b1, 4'(i), 1'b0, 1));
        q.push_back(mk(1'b0, e, 1'b1, 4'(i), 1'b0, 2));
        for (int t = 0; t < w; t++) q.push_back(mk(1'b0, e, 1'b1, 4'(i), 1'b0, 3));
      end
    end
`ifndef TONE_SEQ_LOOP_EN
    r = mk(1'b0, tbl[l-1], 1'b0, 4'(l-1), 1'b1, 4);
    q.push_back(r);
`endif
  endtask

  always @(posedge clk) en_prev <= en;

  // Every-cycle comparison against the model timeline
  always @(negedge clk) begin
    if (chk_on) begin
      if (!en_prev) cur = last;
      else if (q.size() > 0) cur = q.pop_front();
      else cur = idle_of(last);
      last = cur;
      check("outputs{strobe,addr,data,busy,idx,done}",
            {write_strobe, address, data, busy, step_idx, done},
            {cur.strobe, cur.addr, cur.data, cur.busy, cur.idx, cur.done});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int idx, input logic [15:0] v, input bit accept);
    load_we = 1'b1; load_idx = 4'(idx); load_entry = v;
    tick(1);
    load_we = 1'b0;
    if (accept) tbl[idx] = v;
  endtask

  // Returns in the first cycle after the start was sampled
  task automatic play(input int n);
    rec_t r;
    play_len = 5'(n); start = 1'b1;
    tick(1);
    start = 1'b0;
    if (n == 0) begin
      r = idle_of(last); r.done = 1'b1; r.kind = 4;
      q.push_back(r);
    end else begin
      push_play(n);
    end
  endtask

  // Stop held for one cycle; model keeps any unfinished write, then done
  task automatic do_stop();
    rec_t keep[$];
    rec_t r;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    if (last.kind >= 0 && last.kind <= 2) begin
      while (q.size() > 0 && q[0].kind != 3) keep.push_back(q.pop_front());
    end
    r = (keep.size() > 0) ? keep[keep.size()-1] : last;
    r.strobe = 1'b0; r.busy = 1'b0; r.done = 1'b1; r.kind = 4;
    q = keep;
    q.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((q.size() != 0 || busy !== 1'b0) && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_idle_timeout", 32'(k >= budget), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rises[$];
    logic prev;
    rst = 1'b1; en = 1'b1; load_we = 1'b0; load_idx = '0; load_entry = '0;
    play_len = '0; start = 1'b0; stop = 1'b0;
    tick(3);
    check("reset_outputs", {write_strobe, address, data, busy, step_idx, done}, 32'd0);
    rst = 1'b0;
    last = zero_rec();
    chk_on = 1'b1;
    tick(1);

`ifndef TONE_SEQ_LOOP_EN
    // Single step {2,17,wait 2}
    load(0, {3'd2, 5'd17, 8'd2}, 1'b1);
    play(1);
    check("t1_setup_addr", 32'(address), 32'd2);
    check("t1_setup_data", 32'(data), 32'd17);
    check("t1_setup_strobe", 32'(write_strobe), 32'd0);
    check("t1_setup_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_cyc2_strobe", 32'(write_strobe), 32'd1);
    tick(3);
    check("t1_cyc5_hold_strobe", 32'(write_strobe), 32'd0);
    check("t1_cyc5_hold_addr", 32'(address), 32'd2);
    tick(8);
    check("t1_cyc13_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_cyc14_done", 32'(done), 32'd1);
    check("t1_cyc14_busy", 32'(busy), 32'd0);
    tick(1);
    check("t1_cyc15_done", 32'(done), 32'd0);
    check("t1_idle_addr_kept", 32'(address), 32'd2);
    wait_idle(300);

    // Three zero-wait steps, strobe bursts 6 cycles apart
    load(0, {3'd1, 5'd3, 8'd0}, 1'b1);
    load(1, {3'd5, 5'd10, 8'd0}, 1'b1);
    load(2, {3'd7, 5'd31, 8'd0}, 1'b1);
    play(3);
    prev = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (write_strobe && !prev) rises.push_back(c);
      prev = write_strobe;
      tick(1);
    end
    check("t2_burst_count", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) begin
      check("t2_spacing_a", 32'(rises[1] - rises[0]), 32'd6);
      check("t2_spacing_b", 32'(rises[2] - rises[1]), 32'd6);
    end
    wait_idle(300);
`endif

    // Stop during STROBE completes the write, stop during WAIT is immediate
    load(0, {3'd3, 5'd9, 8'd3}, 1'b1);
    load(1, {3'd4, 5'd4, 8'd1}, 1'b1);
    play(2);
    tick(2);
    do_stop();
    check("t3_strobe_not_truncated", 32'(write_strobe), 32'd1);
    tick(2);
    check("t3_abort_done", 32'(done), 32'd1);
    wait_idle(300);
    play(2);
    tick(7);
    do_stop();
    check("t3_wait_abort_done", 32'(done), 32'd1);
    check("t3_wait_abort_busy", 32'(busy), 32'd0);
    wait_idle(300);

`ifndef TONE_SEQ_LOOP_EN
    // Loads while busy are ignored
    play(1);
    tick(1);
    load(0, 16'hFFFF, 1'b0);
    wait_idle(300);
    play(1);
    check("t4_table_kept_addr", 32'(address), 32'd3);
    check("t4_table_kept_data", 32'(data), 32'd9);
    wait_idle(300);
`endif

    // Zero-length start acknowledges only; stop+start does nothing
    play(0);
    check("t4_len0_done", 32'(done), 32'd1);
    check("t4_len0_strobe", 32'(write_strobe), 32'd0);
    tick(1);
    play_len = 5'd1; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("t4_stop_wins_busy", 32'(busy), 32'd0);
    tick(1);
    check("t4_stop_wins_done", 32'(done), 32'd0);

`ifndef TONE_SEQ_LOOP_EN
    // play_len above DEPTH plays all 16 entries
    for (int i = 0; i < DEPTH; i++) load(i, {3'(i), 5'(i * 3 + 1), 8'd0}, 1'b1);
    play(17);
    wait_idle(300);
    check("clamp_last_idx", 32'(step_idx), 32'd15);

    // en low freezes everything mid-strobe
    load(0, {3'd6, 5'd21, 8'd1}, 1'b1);
    play(1);
    tick(1);
    en = 1'b0;
    tick(2);
    check("freeze_strobe_held", 32'(write_strobe), 32'd1);
    tick(1);
    en = 1'b1;
    wait_idle(300);
`else
    // Looping playback: 0,1,0,1... with no done until stop
    load(0, {3'd1, 5'd2, 8'd0}, 1'b1);
    load(1, {3'd2, 5'd3, 8'd0}, 1'b1);
    play(2);
    check("loop_idx_c1", 32'(step_idx), 32'd0);
    tick(6);
    check("loop_idx_c7", 32'(step_idx), 32'd1);
    tick(6);
    check("loop_idx_c13", 32'(step_idx), 32'd0);
    check("loop_no_done", 32'(done), 32'd0);
    tick(1);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(4);
    do_stop();
    wait_idle(300);
    load(0, {3'd6, 5'd21, 8'd1}, 1'b1);
`endif

    // Reset mid-strobe drops everything; table survives
    play(1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    q.delete();
    last = zero_rec();
    check("rst_outputs", {write_strobe, address, data, busy, step_idx, done}, 32'd0);
    tick(1);
    play(1);
    check("rst_replay_addr", 32'(address), 32'd6);
    check("rst_replay_data", 32'(data), 32'd21);
`ifdef TONE_SEQ_LOOP_EN
    tick(3);
    do_stop();
`endif
    wait_idle(300);
    tick(2);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
